// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with an integrated busy scoreboard.
//   clk, rstn            : rising-edge clock, asynchronous active-low reset
//   read_reg/read_data   : NRD combinational read ports (index / data)
//   read_busy            : per-port hazard flag (pending write on that register)
//   write_en/reg/data    : writeback port, also clears the busy bit
//   issue_en/issue_reg   : destination of an issuing instruction, sets the busy bit
//   any_busy             : OR of all registered busy bits
//   dbg_sel/dbg_data     : debug read of the stored value (never bypassed)
module regfile_sb #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned REG_BITS  = $clog2(REG_COUNT),
  parameter int unsigned NRD       = 2,
  parameter bit          BYPASS    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NRD*REG_BITS-1:0] read_reg,
  output logic [NRD*WIDTH-1:0]    read_data,
  output logic [NRD-1:0]          read_busy,
  input  logic                    write_en,
  input  logic [REG_BITS-1:0]     write_reg,
  input  logic [WIDTH-1:0]        write_data,
  input  logic                    issue_en,
  input  logic [REG_BITS-1:0]     issue_reg,
  output logic                    any_busy,
  input  logic [REG_BITS-1:0]     dbg_sel,
  output logic [WIDTH-1:0]        dbg_data
);

  // Storage spans the full index space so any index is a legal array
  // subscript; entries outside 1..REG_COUNT-1 are masked by w_valid.
  localparam int unsigned DEPTH = 1 << REG_BITS;

  logic [WIDTH-1:0]    r_regs [DEPTH];
  logic [DEPTH-1:0]    r_busy;
  logic [DEPTH-1:0]    w_busy_nxt;
  logic [DEPTH-1:0]    w_valid;
  logic                w_wr_ok;
  logic                w_iss_ok;
  logic [REG_BITS-1:0] w_rd_idx [NRD];

  // Constant mask of writable/readable registers (x0 and out-of-range excluded).
  for (genvar g = 0; g < DEPTH; g++) begin : g_valid
    assign w_valid[g] = (g != 0) && (g < REG_COUNT);
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd_idx
    assign w_rd_idx[p] = read_reg[p*REG_BITS +: REG_BITS];
  end

  assign w_wr_ok  = write_en & w_valid[write_reg];
  assign w_iss_ok = issue_en & w_valid[issue_reg];

  // Register storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[write_reg] <= write_data;
    end
  end

  // Scoreboard next state: writeback clears first so a same-register issue wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok) begin
      w_busy_nxt[write_reg] = 1'b0;
    end
    if (w_iss_ok) begin
      w_busy_nxt[issue_reg] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Read ports: zero for x0/out-of-range, optional same-cycle forwarding.
  always_comb begin
    read_data = '0;
    read_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      if (w_valid[w_rd_idx[p]]) begin
        if (BYPASS && w_wr_ok && (write_reg == w_rd_idx[p])) begin
          read_data[p*WIDTH +: WIDTH] = write_data;
          read_busy[p]                = 1'b0;
        end else begin
          read_data[p*WIDTH +: WIDTH] = r_regs[w_rd_idx[p]];
          read_busy[p]                = r_busy[w_rd_idx[p]];
        end
      end
    end
  end

  assign any_busy = |r_busy;
  assign dbg_data = w_valid[dbg_sel] ? r_regs[dbg_sel] : '0;

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: two instances (bypass on/off) share stimulus;
// the driver queues hand-computed expectations, the monitor checks them.
module tb_regfile_sb;

  localparam int unsigned W  = 32;
  localparam int unsigned RB = 5;

  logic          clk;
  logic          rstn;
  logic [2*RB-1:0] read_reg;
  logic          write_en;
  logic [RB-1:0] write_reg;
  logic [W-1:0]  write_data;
  logic          issue_en;
  logic [RB-1:0] issue_reg;
  logic [RB-1:0] dbg_sel;

  logic [2*W-1:0] rd_b, rd_n;
  logic [1:0]     bz_b, bz_n;
  logic           any_b, any_n;
  logic [W-1:0]   dbg_b, dbg_n;

  regfile_sb #(.BYPASS(1'b1)) u_b (
    .clk(clk), .rstn(rstn), .read_reg(read_reg), .read_data(rd_b), .read_busy(bz_b),
    .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
    .issue_en(issue_en), .issue_reg(issue_reg), .any_busy(any_b),
    .dbg_sel(dbg_sel), .dbg_data(dbg_b)
  );

  regfile_sb #(.BYPASS(1'b0)) u_n (
    .clk(clk), .rstn(rstn), .read_reg(read_reg), .read_data(rd_n), .read_busy(bz_n),
    .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
    .issue_en(issue_en), .issue_reg(issue_reg), .any_busy(any_n),
    .dbg_sel(dbg_sel), .dbg_data(dbg_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] d0, d1, dbg, nd0, nd1;
    logic         b0, b1, any, nb0, nb1;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input string field, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
    end
  endtask

  task automatic push(input string name,
                      input logic [W-1:0] d0, input logic [W-1:0] d1,
                      input logic b0, input logic b1, input logic any,
                      input logic [W-1:0] dbg,
                      input logic [W-1:0] nd0, input logic [W-1:0] nd1,
                      input logic nb0, input logic nb1);
    exp_t e;
    e.name = name; e.d0 = d0; e.d1 = d1; e.b0 = b0; e.b1 = b1; e.any = any;
    e.dbg = dbg; e.nd0 = nd0; e.nd1 = nd1; e.nb0 = nb0; e.nb1 = nb1;
    q.push_back(e);
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.name, "rd0",     rd_b[W-1:0],      e.d0);
        cmp(e.name, "rd1",     rd_b[2*W-1:W],    e.d1);
        cmp(e.name, "busy0",   W'(bz_b[0]),      W'(e.b0));
        cmp(e.name, "busy1",   W'(bz_b[1]),      W'(e.b1));
        cmp(e.name, "any",     W'(any_b),        W'(e.any));
        cmp(e.name, "dbg",     dbg_b,            e.dbg);
        cmp(e.name, "nb_rd0",  rd_n[W-1:0],      e.nd0);
        cmp(e.name, "nb_rd1",  rd_n[2*W-1:W],    e.nd1);
        cmp(e.name, "nb_busy0", W'(bz_n[0]),     W'(e.nb0));
        cmp(e.name, "nb_busy1", W'(bz_n[1]),     W'(e.nb1));
        cmp(e.name, "nb_any",  W'(any_n),        W'(e.any));
        cmp(e.name, "nb_dbg",  dbg_n,            e.dbg);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [RB-1:0] a, input logic [RB-1:0] b);
    read_reg = {b, a};
  endtask

  initial begin
    rstn = 1'b0; read_reg = '0; write_en = 1'b0; write_reg = '0; write_data = '0;
    issue_en = 1'b0; issue_reg = '0; dbg_sel = '0;
    #10 rstn = 1'b1;

    // Reset state.
    step(); rd(5, 6);
    push("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Writes on successive edges, then readback.
    step(); write_en = 1'b1; write_reg = 5;  write_data = 42;
    step(); write_reg = 6;  write_data = 100;
    step(); write_reg = 11; write_data = 77;
    step(); write_en = 1'b0; dbg_sel = 11;
    push("wr_rd", 42, 100, 0, 0, 0, 77, 42, 100, 0, 0);

    // Negative value stored unmodified.
    step(); write_en = 1'b1; write_reg = 7; write_data = W'(-5);
    step(); write_en = 1'b0; rd(7, 5); dbg_sel = 7;
    push("neg", 32'hFFFF_FFFB, 42, 0, 0, 0, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 42, 0, 0);

    // x0 protection: issue and write to x0 have no effect.
    step(); issue_en = 1'b1; issue_reg = 0; rd(0, 0); dbg_sel = 0;
    step(); issue_en = 1'b0; write_en = 1'b1; write_reg = 0; write_data = 123;
    push("x0_wr", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); write_en = 1'b0;
    push("x0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Scoreboard: issue x5, visible next cycle.
    step(); issue_en = 1'b1; issue_reg = 5; rd(5, 6);
    push("iss_same", 42, 100, 0, 0, 0, 0, 42, 100, 0, 0);
    step(); issue_en = 1'b0;
    push("busy5", 42, 100, 1, 0, 1, 0, 42, 100, 1, 0);

    // Writeback cycle: bypass forwards data and clears hazard, no-bypass does not.
    step(); write_en = 1'b1; write_reg = 5; write_data = 9;
    push("byp", 9, 100, 0, 0, 1, 0, 42, 100, 1, 0);
    step(); write_en = 1'b0;
    push("clr5", 9, 100, 0, 0, 0, 0, 9, 100, 0, 0);

    // Simultaneous issue and write of x6: data stored, busy set.
    step(); issue_en = 1'b1; issue_reg = 6; write_en = 1'b1; write_reg = 6;
    write_data = 55; rd(6, 11);
    push("sim6_cyc", 55, 77, 0, 0, 0, 0, 100, 77, 0, 0);
    step(); issue_en = 1'b0; write_en = 1'b0;
    push("sim6", 55, 77, 1, 0, 1, 0, 55, 77, 1, 0);

    // Make x11 busy, then issue x6 while writing x11.
    step(); issue_en = 1'b1; issue_reg = 11;
    step(); issue_en = 1'b0;
    push("busy11", 55, 77, 1, 1, 1, 0, 55, 77, 1, 1);
    step(); issue_en = 1'b1; issue_reg = 6; write_en = 1'b1; write_reg = 11;
    write_data = 88;
    step(); issue_en = 1'b0; write_en = 1'b0;
    push("iss6_wr11", 55, 88, 1, 0, 1, 0, 55, 88, 1, 0);

    // Reset mid-operation with x5, x6, x11 busy.
    step(); issue_en = 1'b1; issue_reg = 5;
    step(); issue_reg = 11;
    step(); issue_en = 1'b0; rd(5, 11); dbg_sel = 6;
    push("pre_rst", 9, 88, 1, 1, 1, 55, 9, 88, 1, 1);
    @(posedge clk);
    #3 rstn = 1'b0;
    push("in_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3 rstn = 1'b1;
    step(); rd(6, 11); dbg_sel = 11;
    push("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Drain with a bounded wait.
    for (int i = 0; i < 5 && q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
